// File: rtl/fb_slot_scheduler.sv
// Framebuffer RAM port scheduler: scanout prefetch, optional clear engine, pixel writer.
// Define FB_CLEAR_EN to build the hardware clear engine.
module fb_slot_scheduler #(
  parameter int unsigned FB_W = 320,
  parameter int unsigned FB_H = 240,
  parameter int unsigned AW   = 17
) (
  input  logic          vgaclk,
  input  logic          rst,
  input  logic [9:0]    hc,
  input  logic [9:0]    vc,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [7:0]    pix_color,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          clr_start,
  input  logic [7:0]    clr_color,
  output logic          clr_busy,
  output logic          clr_done
);
  localparam int unsigned NPIX = FB_W * FB_H;

  logic [9:0]    th, tv, nh, nv;
  logic          fetch, fetch_q, next_active;
  logic [AW-1:0] fetch_addr, addr_q;
  logic [AW-1:0] clr_ptr;
  logic [7:0]    clr_val;

  // Target the pixel two clocks ahead so RAM latency plus the output register line up.
  always_comb begin
    th          = (hc >= 10'd798) ? hc - 10'd798 : hc + 10'd2;
    tv          = (hc < 10'd798) ? vc : ((vc == 10'd524) ? 10'd0 : vc + 10'd1);
    fetch       = !hc[0] && (th < 10'd640) && (tv < 10'd480);
    fetch_addr  = AW'((32'(tv) >> 1) * FB_W + (32'(th) >> 1));
    nh          = (hc == 10'd799) ? 10'd0 : hc + 10'd1;
    nv          = (hc != 10'd799) ? vc : ((vc == 10'd524) ? 10'd0 : vc + 10'd1);
    next_active = (nh < 10'd640) && (nv < 10'd480);
  end

  always_comb begin
    wr_ready  = !fetch && !clr_busy;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = 8'h00;
    if (fetch) begin
      ram_addr = fetch_addr;
    end else if (clr_busy) begin
      ram_addr  = clr_ptr;
      ram_we    = 1'b1;
      ram_wdata = clr_val;
    end else if (wr_valid) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      ram_we    = 32'(wr_addr) < NPIX;
    end
    if (!rst) ram_we = 1'b0;
  end

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      fetch_q   <= 1'b0;
      pix_color <= 8'h00;
    end else begin
      addr_q  <= ram_addr;
      fetch_q <= fetch;
      if (fetch_q) pix_color <= ram_rdata;
      else if (!next_active) pix_color <= 8'h00;
    end
  end

`ifdef FB_CLEAR_EN
  typedef enum logic {StIdle, StClear} clr_state_e;
  clr_state_e state_q;

  // Clear writes steal every free slot; the pointer only advances when a write went out.
  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      clr_ptr  <= '0;
      clr_val  <= 8'h00;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q  <= StClear;
            clr_ptr  <= '0;
            clr_val  <= clr_color;
            clr_busy <= 1'b1;
          end
        end
        StClear: begin
          if (!fetch) begin
            if (clr_ptr == AW'(NPIX - 1)) begin
              state_q  <= StIdle;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end else begin
              clr_ptr <= clr_ptr + AW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_color};
  assign clr_ptr    = '0;
  assign clr_val    = 8'h00;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

endmodule

// File: tb/tb_fb_slot_scheduler.sv
// Directed bench for fb_slot_scheduler: slot vectors, scanout alignment, arbitration, clear.
module tb_fb_slot_scheduler;
  localparam int unsigned AW = 17;

  logic          vgaclk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    hc = '0, vc = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = '0;
  logic [7:0]    pix_color;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready;
  logic          clr_start = 1'b0;
  logic [7:0]    clr_color = '0;
  logic          clr_busy, clr_done;

  fb_slot_scheduler dut (
    .vgaclk(vgaclk), .rst(rst), .hc(hc), .vc(vc),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_color(pix_color), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #20 vgaclk = ~vgaclk;

  // Model RAM whose content at each address is addr[7:0].
  always @(posedge vgaclk) ram_rdata <= ram_addr[7:0];

  int checks = 0;
  int errors = 0;
  int hcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  // Walk a blanking line: every cycle is a free slot.
  task automatic blank_drive();
    hc = 10'(hcnt);
    vc = 10'd500;
    hcnt = (hcnt == 799) ? 0 : hcnt + 1;
  endtask

  typedef struct {
    logic [9:0]    h, v;
    logic          wv;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [7:0]    ewd;
    logic          erdy;
    logic          ca, cd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int wcnt, bad, dones, post, n;
    logic [7:0] exp_pix;

    vecs[0]  = '{10'd798, 10'd524, 1'b0, 17'd0,     8'h00, 17'd0,     1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{10'd798, 10'd479, 1'b1, 17'd5,     8'h11, 17'd5,     1'b1, 8'h11, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{10'd0,   10'd0,   1'b1, 17'd5,     8'h11, 17'd1,     1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{10'd636, 10'd3,   1'b0, 17'd0,     8'h00, 17'd639,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{10'd638, 10'd3,   1'b1, 17'd100,   8'hE0, 17'd100,   1'b1, 8'hE0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{10'd1,   10'd0,   1'b1, 17'd76800, 8'h33, 17'd0,     1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{10'd798, 10'd9,   1'b0, 17'd0,     8'h00, 17'd1600,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{10'd100, 10'd100, 1'b1, 17'd7,     8'h07, 17'd16051, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{10'd4,   10'd479, 1'b0, 17'd0,     8'h00, 17'd76483, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{10'd799, 10'd524, 1'b1, 17'd76799, 8'h5A, 17'd76799, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{10'd700, 10'd10,  1'b0, 17'd0,     8'h00, 17'd76799, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{10'd200, 10'd490, 1'b1, 17'd3,     8'hC3, 17'd3,     1'b1, 8'hC3, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{10'd639, 10'd479, 1'b0, 17'd0,     8'h00, 17'd3,     1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset held with timing running and a writer pushing on free slots.
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 8'hFF; vc = 10'd524;
    for (int i = 0; i < 10; i++) begin
      hc = 10'(790 + i);
      #1;
      chk("reset ram_we", 32'(ram_we), 32'd0);
      chk("reset pix_color", 32'(pix_color), 32'd0);
      chk("reset clr_busy", 32'(clr_busy), 32'd0);
      tick();
    end
    rst = 1'b1;
    wr_valid = 1'b0;

    // Single-cycle slot vectors.
    for (int i = 0; i < 13; i++) begin
      hc = vecs[i].h; vc = vecs[i].v;
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      #1;
      if (vecs[i].ca) chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].ea));
      chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].ewe));
      if (vecs[i].cd) chk($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].ewd));
      chk($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].erdy));
      tick();
    end
    wr_valid = 1'b0;

    // Scanout alignment at line start of vc=10 (fb row 5).
    for (int h = 796; h < 800; h++) begin
      hc = 10'(h); vc = 10'd9; #1; tick();
    end
    for (int h = 0; h < 12; h++) begin
      hc = 10'(h); vc = 10'd10; #1;
      if (h < 10) begin
        exp_pix = 8'((1600 + h / 2) & 255);
        chk($sformatf("scan start hc=%0d", h), 32'(pix_color), 32'(exp_pix));
      end
      tick();
    end
    // Line end: last column then blank.
    for (int h = 626; h < 646; h++) begin
      hc = 10'(h); vc = 10'd10; #1;
      if (h >= 628) begin
        exp_pix = (h < 640) ? 8'((1600 + h / 2) & 255) : 8'h00;
        chk($sformatf("scan end hc=%0d", h), 32'(pix_color), 32'(exp_pix));
      end
      tick();
    end

    // Writer arbitration over an active line.
    wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 8'hE0; vc = 10'd20;
    for (int h = 0; h < 640; h++) begin
      hc = 10'(h); #1;
      chk($sformatf("arb wr_ready hc=%0d", h), 32'(wr_ready), 32'(hc[0] || h >= 638));
      chk($sformatf("arb ram_we hc=%0d", h), 32'(ram_we), 32'(hc[0] || h >= 638));
      tick();
    end

`ifdef FB_CLEAR_EN
    // Full clear; the writer wins the start cycle, then is locked out.
    hcnt = 1;
    blank_drive();
    clr_start = 1'b1; clr_color = 8'h1C; wr_addr = 17'd42; wr_data = 8'hA5; #1;
    chk("start cycle writer ram_we", 32'(ram_we), 32'd1);
    chk("start cycle writer ram_addr", 32'(ram_addr), 32'd42);
    chk("start cycle writer wr_ready", 32'(wr_ready), 32'd1);
    tick();
    clr_start = 1'b0; clr_color = 8'h00;
    wcnt = 0; bad = 0; dones = 0; post = 0;
    for (int k = 0; k < 80000 && post < 4; k++) begin
      blank_drive();
      if (k == 500) begin
        clr_start = 1'b1; clr_color = 8'h55;
      end else begin
        clr_start = 1'b0;
      end
      #1;
      if (clr_done) dones++;
      if (clr_busy) begin
        if (!ram_we || 32'(ram_addr) != wcnt || ram_wdata != 8'h1C || wr_ready) bad++;
        wcnt++;
      end else if (dones > 0) begin
        post++;
      end
      tick();
    end
    clr_start = 1'b0;
    chk("clear write count", 32'(wcnt), 32'd76800);
    chk("clear bad cycles", 32'(bad), 32'd0);
    chk("clear done pulses", 32'(dones), 32'd1);
    blank_drive(); #1;
    chk("after clear wr_ready", 32'(wr_ready), 32'd1);
    chk("after clear clr_busy", 32'(clr_busy), 32'd0);
    tick();

    // Reset in the middle of a clear.
    blank_drive(); wr_valid = 1'b0; clr_start = 1'b1; clr_color = 8'h1C; #1;
    tick();
    clr_start = 1'b0; wr_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 2000 && n < 1000; k++) begin
      blank_drive(); #1;
      if (clr_busy && ram_we) n++;
      tick();
    end
    chk("mid-clear writes", 32'(n), 32'd1000);
    rst = 1'b0; #1;
    chk("mid-clear reset clr_busy", 32'(clr_busy), 32'd0);
    chk("mid-clear reset ram_we", 32'(ram_we), 32'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (clr_done || clr_busy) bad++;
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      blank_drive(); #1;
      if (clr_done) bad++;
      tick();
    end
    chk("mid-clear no done", 32'(bad), 32'd0);
    wr_valid = 1'b0; blank_drive(); clr_start = 1'b1; #1;
    tick();
    clr_start = 1'b0; blank_drive(); #1;
    chk("restart clr_busy", 32'(clr_busy), 32'd1);
    chk("restart ram_addr", 32'(ram_addr), 32'd0);
    chk("restart ram_we", 32'(ram_we), 32'd1);
    chk("restart ram_wdata", 32'(ram_wdata), 32'h1C);
    tick();
`else
    // Without the clear engine, clr_start must have no effect.
    hcnt = 1;
    blank_drive();
    clr_start = 1'b1; clr_color = 8'h1C; wr_addr = 17'd42; wr_data = 8'hA5; #1;
    tick();
    clr_start = 1'b0;
    blank_drive(); #1;
    chk("noclr clr_busy", 32'(clr_busy), 32'd0);
    chk("noclr clr_done", 32'(clr_done), 32'd0);
    chk("noclr wr_ready", 32'(wr_ready), 32'd1);
    chk("noclr ram_addr", 32'(ram_addr), 32'd42);
    chk("noclr ram_wdata", 32'(ram_wdata), 32'hA5);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
